// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the instruction ROM and buffers up to two
// {pc, instr} pairs for decode. Optional misaligned-redirect fault: define FETCH_MISALIGN_EN.
module instr_fetch_unit #(
  parameter int                  ADDR_BITS = 4,
  parameter int                  PC_BITS   = 32,
  parameter logic [PC_BITS-1:0]  RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [ADDR_BITS-1:0] rom_addr,
  input  logic [31:0]          rom_data,
  input  logic                 redirect_valid,
  input  logic [PC_BITS-1:0]   redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [PC_BITS-1:0]   out_pc,
  output logic                 fetch_fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [PC_BITS-1:0] pc;
    logic [31:0]        instr;
  } fetch_ent_t;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PC_BITS-1:0] pc_q, pc_d;
  logic [1:0]         count_q, count_d;
  fetch_ent_t         ent_q [2];
  fetch_ent_t         ent_d [2];
  fetch_ent_t         new_ent;
  logic [1:0]         slot;
  logic               push, pop;
  logic [PC_BITS-1:0] redir_pc_al;

  assign rom_addr    = pc_q[ADDR_BITS+1:2];
  assign out_valid   = (count_q != 2'd0);
  assign pop         = out_valid & out_ready;
  assign push        = (state_q == RUN) & ~redirect_valid & ((count_q < 2'd2) | pop);
  assign redir_pc_al = {redirect_pc[PC_BITS-1:2], 2'b00};

  // Head is always ent_q[0]; a push lands in the first free slot after any pop.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    ent_d        = ent_q;
    new_ent.pc    = pc_q;
    new_ent.instr = rom_data;
    slot         = count_q - {1'b0, pop};
    if (redirect_valid) begin
      count_d = 2'd0;
      pc_d    = redir_pc_al;
      state_d = RUN;
`ifdef FETCH_MISALIGN_EN
      if (redirect_pc[1:0] != 2'b00) begin
        state_d = FAULT;
        pc_d    = pc_q;
      end
`endif
    end else begin
      if (pop)
        ent_d[0] = ent_q[1];
      if (push) begin
        pc_d = pc_q + PC_BITS'(4);
        if (slot == 2'd0)
          ent_d[0] = new_ent;
        else
          ent_d[1] = new_ent;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      count_q <= 2'd0;
      for (int i = 0; i < 2; i++)
        ent_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      for (int i = 0; i < 2; i++)
        ent_q[i] <= ent_d[i];
    end
  end

  assign out_instr = out_valid ? ent_q[0].instr : NOP;
  assign out_pc    = out_valid ? ent_q[0].pc    : '0;

`ifdef FETCH_MISALIGN_EN
  assign fetch_fault = (state_q == FAULT);
`else
  // Low redirect bits are dropped when the fault feature is off.
  logic unused_lowbits;
  assign unused_lowbits = ^redirect_pc[1:0];
  assign fetch_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  logic [31:0] rom [16];
  assign rom_data = rom[rom_addr];

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

`ifdef FETCH_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  ent_t        mq[$];
  logic [31:0] mpc = '0;
  bit          mfault = 1'b0;
  bit          mlive = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reference model: a bounded queue of fetched words, updated at each rising edge.
  initial begin
    bit popm;
    ent_t e;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        mpc    = 32'h0;
        mfault = 1'b0;
        mlive  = 1'b1;
      end else if (redirect_valid) begin
        mq.delete();
        if (MIS_EN && redirect_pc[1:0] != 2'b00)
          mfault = 1'b1;
        else begin
          mfault = 1'b0;
          mpc    = redirect_pc & 32'hFFFF_FFFC;
        end
      end else begin
        popm = (mq.size() > 0) && out_ready;
        if (popm)
          void'(mq.pop_front());
        if (!mfault && mq.size() < 2) begin
          e.pc    = mpc;
          e.instr = rom[(mpc / 4) % 16];
          mq.push_back(e);
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mlive) begin
        chk("m_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
        chk("m_pc",    out_pc,    (mq.size() != 0) ? mq[0].pc    : 32'h0);
        chk("m_instr", out_instr, (mq.size() != 0) ? mq[0].instr : 32'h0000_0013);
        chk("m_fault", {31'b0, fetch_fault}, {31'b0, mfault});
        chk("m_romaddr", {28'b0, rom_addr}, (mpc / 4) % 16);
      end
    end
  end

  initial begin
    logic [31:0] t1_instr [4];
    logic [31:0] pat;
    bit found;
    rom[0] = 32'h0010_0093;
    rom[1] = 32'h0010_8093;
    rom[2] = 32'h0001_0113;
    rom[3] = 32'hFFE1_F0E3;
    for (int i = 4; i < 16; i++)
      rom[i] = 32'hA000_0000 | i;
    t1_instr[0] = 32'h0010_0093;
    t1_instr[1] = 32'h0010_8093;
    t1_instr[2] = 32'h0001_0113;
    t1_instr[3] = 32'hFFE1_F0E3;

    // Reset state
    step(3);
    @(negedge clk);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'h0000_0013);
    chk("rst_pc", out_pc, 32'h0);

    // T1: streaming after reset
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_valid", {31'b0, out_valid}, 32'd1);
      chk("t1_pc", out_pc, 32'(i * 4));
      chk("t1_instr", out_instr, t1_instr[i]);
    end
    chk("t1_model_pin", mq[0].pc, 32'hC);

    // T2: backpressure after reset, then drain in order
    step();
    rst = 1'b1;
    out_ready = 1'b0;
    step(2);
    rst = 1'b0;
    step(5);
    @(negedge clk);
    chk("t2_romaddr", {28'b0, rom_addr}, 32'd2);
    chk("t2_pc", out_pc, 32'h0);
    chk("t2_instr", out_instr, 32'h0010_0093);
    chk("t2_model_pin", mq.size(), 32'd2);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_drain_pc", out_pc, 32'(i * 4));
    end

    // T3: redirect while full
    step();
    out_ready = 1'b0;
    step(3);
    redirect_valid = 1'b1;
    redirect_pc = 32'h4;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t3_flush_valid", {31'b0, out_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("t3_valid", {31'b0, out_valid}, 32'd1);
    chk("t3_pc", out_pc, 32'h4);
    chk("t3_instr", out_instr, 32'h0010_8093);
    @(negedge clk);
    chk("t3_hold_pc", out_pc, 32'h4);

    // T5: reset while full with a redirect pending
    step(2);
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    step();
    rst = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("t5_valid", {31'b0, out_valid}, 32'd1);
    chk("t5_pc", out_pc, 32'h0);

    // T4: free run through the ROM alias
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (out_valid && out_pc == 32'h40) found = 1'b1;
    end
    chk("t4_reach_40", {31'b0, found}, 32'd1);
    chk("t4_alias_instr", out_instr, 32'h0010_0093);
    @(negedge clk);
    chk("t4_pc44", out_pc, 32'h44);
    @(negedge clk);
    chk("t4_pc48", out_pc, 32'h48);

    // T6: misaligned redirect
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h6;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_EN
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_fault", {31'b0, fetch_fault}, 32'd1);
      chk("t6_valid", {31'b0, out_valid}, 32'd0);
    end
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8;
    step();
    redirect_valid = 1'b0;
    step();
    @(negedge clk);
    chk("t6_fault_clr", {31'b0, fetch_fault}, 32'd0);
    chk("t6_pc", out_pc, 32'h8);
    chk("t6_instr", out_instr, 32'h0001_0113);
`else
    step();
    @(negedge clk);
    chk("t6_fault", {31'b0, fetch_fault}, 32'd0);
    chk("t6_pc", out_pc, 32'h4);
    chk("t6_instr", out_instr, 32'h0010_8093);
`endif

    // PC wrap at the top of the address space
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    step();
    @(negedge clk);
    chk("wrap_pc0", out_pc, 32'hFFFF_FFF8);
    chk("wrap_instr0", out_instr, 32'hA000_000E);
    @(negedge clk);
    chk("wrap_pc1", out_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_pc2", out_pc, 32'h0);
    chk("wrap_instr2", out_instr, 32'h0010_0093);

    // Irregular ready pattern, checked by the model only
    pat = 32'hB5D3_6A19;
    for (int i = 0; i < 32; i++) begin
      step();
      out_ready = pat[i];
    end
    step(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
